ddc_out_arbiter: RTL

Merges the eight result streams of the 4-channel DDC into one tagged output stream with valid/ready handshaking. Each channel has a pair stage plus a small pair FIFO; a round-robin scheduler drains them. Each pair is sent as an I word then a Q word. The block sits between the DDC channel outputs and the downstream packetiser/DMA, and absorbs short downstream stalls.

---
 rtl/ddc_pkg.sv | 36 +++
 rtl/ddc_pair_fifo.sv | 117 +++++++++++
 rtl/ddc_out_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/ddc_pkg.sv
// rtl/ddc_pkg.sv - shared constants, scheduler states and helpers for the DDC output arbiter
package ddc_pkg;

   localparam int NUM_CH = 4;
   localparam int CH_W   = 2;

   localparam logic IQ_I = 1'b0;
   localparam logic IQ_Q = 1'b1;

   // Tag layout: {channel[1:0], iq}
   localparam int TAG_W      = 3;
   localparam int TAG_IQ_LSB = 0;
   localparam int TAG_CH_LSB = 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEND_I = 2'd1,
      ST_SEND_Q = 2'd2
   } sched_state_t;

   // First requesting channel searching from last+1 upwards, wrapping; last itself has lowest priority.
   function automatic logic [CH_W-1:0] rr_pick(input logic [NUM_CH-1:0] req,
                                                input logic [CH_W-1:0]   last);
      logic [CH_W-1:0] idx;
      rr_pick = last;
      for (int k = NUM_CH; k >= 1; k--) begin
         idx = last + CH_W'(k);
         if (req[idx]) rr_pick = idx;
      end
   endfunction

   function automatic logic [TAG_W-1:0] make_tag(input logic [CH_W-1:0] ch, input logic iq);
      make_tag = {ch, iq};
   endfunction

endpackage

// File: rtl/ddc_pair_fifo.sv
// rtl/ddc_pair_fifo.sv - per-channel I/Q pair staging, pair FIFO and sticky error flags
module ddc_pair_fifo
   import ddc_pkg::*;
#(
   parameter  int W     = 24,
   parameter  int DEPTH = 4,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             en,
   input  logic [W-1:0]     i_data,
   input  logic             i_valid,
   input  logic [W-1:0]     q_data,
   input  logic             q_valid,
   input  logic             pop,
   input  logic             clr_flags,
   output logic [W-1:0]     head_i,
   output logic [W-1:0]     head_q,
   output logic [W-1:0]     next_i,
   output logic [CNT_W-1:0] count,
   output logic             empty,
   output logic             overflow,
   output logic             sync_err
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]     mem_i [DEPTH];
   logic [W-1:0]     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] cnt;

   logic [W-1:0] stg_i, stg_q;
   logic         have_i, have_q;

   logic         cap_i, cap_q, pair_done, full, push_ok, pop_ok, ovf_set, sync_set;
   logic [W-1:0] pair_i, pair_q;

   // Pair completion, FIFO accept and flag-set decisions for this edge
   always_comb begin
      cap_i     = en & i_valid;
      cap_q     = en & q_valid;
      pair_done = (have_i | cap_i) & (have_q | cap_q);
      pair_i    = cap_i ? i_data : stg_i;
      pair_q    = cap_q ? q_data : stg_q;
      full      = (cnt == CNT_W'(DEPTH));
      pop_ok    = pop & (cnt != '0);
      push_ok   = pair_done & (~full | pop_ok);
      ovf_set   = pair_done & full & ~pop_ok;
      sync_set  = (cap_i & have_i) | (cap_q & have_q);
   end

   // Staging: hold a lone I or Q until its partner arrives; a repeat overwrites
   always_ff @(posedge clk) begin
      if (!resetn) begin
         stg_i  <= '0;
         stg_q  <= '0;
         have_i <= 1'b0;
         have_q <= 1'b0;
      end else if (pair_done) begin
         have_i <= 1'b0;
         have_q <= 1'b0;
      end else begin
         if (cap_i) begin
            stg_i  <= i_data;
            have_i <= 1'b1;
         end
         if (cap_q) begin
            stg_q  <= q_data;
            have_q <= 1'b1;
         end
      end
   end

   // Pair storage; contents are only meaningful between rd_ptr and wr_ptr
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_i[wr_ptr] <= pair_i;
         mem_q[wr_ptr] <= pair_q;
      end
   end

   // Pointers and occupancy
   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
         cnt <= cnt + CNT_W'(push_ok) - CNT_W'(pop_ok);
      end
   end

   // Sticky flags; clear wins over a set on the same edge
   always_ff @(posedge clk) begin
      if (!resetn) begin
         overflow <= 1'b0;
         sync_err <= 1'b0;
      end else if (clr_flags) begin
         overflow <= 1'b0;
         sync_err <= 1'b0;
      end else begin
         if (ovf_set)  overflow <= 1'b1;
         if (sync_set) sync_err <= 1'b1;
      end
   end

   assign head_i = mem_i[rd_ptr];
   assign head_q = mem_q[rd_ptr];
   assign next_i = mem_i[rd_ptr + PTR_W'(1)];
   assign count  = cnt;
   assign empty  = (cnt == '0);

endmodule

// File: rtl/ddc_out_arbiter.sv
// rtl/ddc_out_arbiter.sv - round-robin merge of four DDC I/Q channels into one tagged stream
module ddc_out_arbiter
   import ddc_pkg::*;
#(
   parameter int OUTPUT_WIDTH = 24,
   parameter int DEPTH        = 4
) (
   input  logic                    CLK,
   input  logic                    nRST,
   input  logic                    En,
   input  logic [OUTPUT_WIDTH-1:0] Data_I0,
   input  logic [OUTPUT_WIDTH-1:0] Data_I1,
   input  logic [OUTPUT_WIDTH-1:0] Data_I2,
   input  logic [OUTPUT_WIDTH-1:0] Data_I3,
   input  logic                    Data_I0_Valid,
   input  logic                    Data_I1_Valid,
   input  logic                    Data_I2_Valid,
   input  logic                    Data_I3_Valid,
   input  logic [OUTPUT_WIDTH-1:0] Data_Q0,
   input  logic [OUTPUT_WIDTH-1:0] Data_Q1,
   input  logic [OUTPUT_WIDTH-1:0] Data_Q2,
   input  logic [OUTPUT_WIDTH-1:0] Data_Q3,
   input  logic                    Data_Q0_Valid,
   input  logic                    Data_Q1_Valid,
   input  logic                    Data_Q2_Valid,
   input  logic                    Data_Q3_Valid,
   output logic [OUTPUT_WIDTH-1:0] Out_Data,
   output logic [TAG_W-1:0]        Out_Tag,
   output logic                    Out_Last,
   output logic                    Out_Valid,
   input  logic                    Out_Ready,
   output logic [NUM_CH-1:0]       Overflow,
   output logic [NUM_CH-1:0]       Sync_Err,
   input  logic                    Clr_Flags
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [OUTPUT_WIDTH-1:0] in_i   [NUM_CH];
   logic [OUTPUT_WIDTH-1:0] in_q   [NUM_CH];
   logic [NUM_CH-1:0]       in_iv, in_qv;

   logic [OUTPUT_WIDTH-1:0] head_i [NUM_CH];
   logic [OUTPUT_WIDTH-1:0] head_q [NUM_CH];
   logic [OUTPUT_WIDTH-1:0] next_i [NUM_CH];
   logic [CNT_W-1:0]        cnt    [NUM_CH];
   logic [NUM_CH-1:0]       empty;
   logic [NUM_CH-1:0]       pop;

   sched_state_t            state;
   logic [CH_W-1:0]         cur_ch, last_served;

   logic [NUM_CH-1:0]       nonempty, post_ne;
   logic [CH_W-1:0]         idle_ch, next_ch;
   logic [OUTPUT_WIDTH-1:0] next_word;

   assign in_i  = '{Data_I0, Data_I1, Data_I2, Data_I3};
   assign in_q  = '{Data_Q0, Data_Q1, Data_Q2, Data_Q3};
   assign in_iv = {Data_I3_Valid, Data_I2_Valid, Data_I1_Valid, Data_I0_Valid};
   assign in_qv = {Data_Q3_Valid, Data_Q2_Valid, Data_Q1_Valid, Data_Q0_Valid};

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      ddc_pair_fifo #(
         .W     (OUTPUT_WIDTH),
         .DEPTH (DEPTH)
      ) u_fifo (
         .clk       (CLK),
         .resetn    (nRST),
         .en        (En),
         .i_data    (in_i[g]),
         .i_valid   (in_iv[g]),
         .q_data    (in_q[g]),
         .q_valid   (in_qv[g]),
         .pop       (pop[g]),
         .clr_flags (Clr_Flags),
         .head_i    (head_i[g]),
         .head_q    (head_q[g]),
         .next_i    (next_i[g]),
         .count     (cnt[g]),
         .empty     (empty[g]),
         .overflow  (Overflow[g]),
         .sync_err  (Sync_Err[g])
      );
   end

   // Channel selection; the back-to-back choice sees the served FIFO as already popped
   always_comb begin
      nonempty        = ~empty;
      post_ne         = nonempty;
      post_ne[cur_ch] = (cnt[cur_ch] > CNT_W'(1));
      pop             = '0;
      if (state == ST_SEND_Q && Out_Ready) pop[cur_ch] = 1'b1;
      idle_ch   = rr_pick(nonempty, last_served);
      next_ch   = rr_pick(post_ne, cur_ch);
      next_word = (next_ch == cur_ch) ? next_i[cur_ch] : head_i[next_ch];
   end

   // Scheduler with registered output word, tag, last and valid
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state       <= ST_IDLE;
         cur_ch      <= '0;
         last_served <= CH_W'(NUM_CH - 1);
         Out_Data    <= '0;
         Out_Tag     <= '0;
         Out_Last    <= 1'b0;
         Out_Valid   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (|nonempty) begin
                  cur_ch    <= idle_ch;
                  Out_Data  <= head_i[idle_ch];
                  Out_Tag   <= make_tag(idle_ch, IQ_I);
                  Out_Last  <= 1'b0;
                  Out_Valid <= 1'b1;
                  state     <= ST_SEND_I;
               end
            end
            ST_SEND_I: begin
               if (Out_Ready) begin
                  Out_Data <= head_q[cur_ch];
                  Out_Tag  <= make_tag(cur_ch, IQ_Q);
                  Out_Last <= 1'b1;
                  state    <= ST_SEND_Q;
               end
            end
            ST_SEND_Q: begin
               if (Out_Ready) begin
                  last_served <= cur_ch;
                  if (|post_ne) begin
                     cur_ch   <= next_ch;
                     Out_Data <= next_word;
                     Out_Tag  <= make_tag(next_ch, IQ_I);
                     Out_Last <= 1'b0;
                     state    <= ST_SEND_I;
                  end else begin
                     Out_Valid <= 1'b0;
                     Out_Last  <= 1'b0;
                     state     <= ST_IDLE;
                  end
               end
            end
            default: begin
               state     <= ST_IDLE;
               Out_Valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
